// File: rtl/bluetooth_tx_sched.sv
// rtl/bluetooth_tx_sched.sv - replays buffered bytes into the UART transmitter
// with an inter-byte gap and a per-byte handshake watchdog.
module bluetooth_tx_sched #(
  parameter logic [18:0] GAP_CYCLES     = 19'd1000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        start,
  input  logic [15:0] length,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [15:0] sent_count
);

  typedef enum logic [2:0] {
    IDLE, READ, LOAD, SEND, WAIT_DONE, GAP, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] sent_q, sent_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rd_en_q, rd_en_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic [23:0] wd_q, wd_d;
  logic [18:0] gap_q, gap_d;
  logic [15:0] sent_inc;
  logic [15:0] addr_inc;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    sent_d     = sent_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    rd_en_d    = 1'b0;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    wd_d       = wd_q;
    gap_d      = gap_q;
    sent_inc   = sent_q + 16'd1;
    addr_inc   = addr_q + 16'd1;

    // Pulse outputs are set on the edge that enters the state owning them.
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != 16'd0) begin
            len_d     = length;
            sent_d    = 16'd0;
            addr_d    = 16'd0;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = 16'd0;
            state_d   = READ;
          end else begin
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        tx_data_d = rd_data;
        state_d   = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          wd_d       = 24'd0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_d = wd_q + 24'd1;
        if (tx_done) begin
          sent_d = sent_inc;
          addr_d = addr_inc;
          if (sent_inc == len_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
          end else if (GAP_CYCLES == 19'd0) begin
            rd_en_d   = 1'b1;
            rd_addr_d = addr_inc;
            state_d   = READ;
          end else begin
            gap_d   = 19'd0;
            state_d = GAP;
          end
        end else if (wd_q == TIMEOUT_CYCLES - 24'd1) begin
          abort_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_CYCLES - 19'd1) begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q;
          state_d   = READ;
        end else begin
          gap_d = gap_q + 19'd1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      addr_q     <= 16'd0;
      sent_q     <= 16'd0;
      rd_addr_q  <= 16'd0;
      tx_data_q  <= 8'd0;
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      wd_q       <= 24'd0;
      gap_q      <= 19'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      sent_q     <= sent_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      rd_en_q    <= rd_en_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign abort      = abort_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_bluetooth_tx_sched.sv
// tb/tb_bluetooth_tx_sched.sv - event-timeline model of the tx sequencer with
// a buffer RAM and UART stand-in, plus directed job scenarios.
module tb_bluetooth_tx_sched;
  localparam int GAP = 4;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset_p, start;
  logic [15:0] length;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy, tx_done;
  logic        busy, done, abort;
  logic [15:0] sent_count;

  bluetooth_tx_sched #(.GAP_CYCLES(19'd4), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset_p(reset_p), .start(start), .length(length),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .busy(busy), .done(done), .abort(abort), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  logic [7:0] mem [16];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];

  // UART stand-in: busy for 10 cycles after tx_start, then one tx_done pulse
  logic u_busy = 1'b0;
  logic busy_force;
  int   u_cnt = 0;
  int   u_idx = 0;
  int   drop_idx;
  bit   u_drop = 1'b0;
  assign tx_busy = u_busy | busy_force;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (reset_p) begin
      u_busy = 1'b0;
      u_cnt  = 0;
    end else begin
      if (u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) begin
          u_busy  = 1'b0;
          tx_done = !u_drop;
        end
      end
      if (tx_start) begin
        u_idx++;
        u_busy = 1'b1;
        u_cnt  = 10;
        u_drop = (u_idx == drop_idx);
      end
    end
  end

  // Timeline model: edges at which each event is due, derived from the inputs
  int          e = 0;
  int          rd_at = -100, s_at = 0, idle_at = 0, len = 0, txdone_edge = 0;
  bit          job = 0, waiting = 0;
  logic [15:0] addr = 0;
  logic        m_busy = 0, m_done = 0, m_abort = 0, m_rd = 0, m_txs = 0;
  logic [15:0] m_sent = 0, m_rdaddr = 0;
  logic [7:0]  m_txdata = 0;

  always @(posedge clk) begin
    e++;
    m_done = 0; m_abort = 0; m_rd = 0; m_txs = 0;
    if (tx_done) txdone_edge = e;
    if (reset_p) begin
      job = 0; waiting = 0; m_busy = 0; m_sent = 0; m_rdaddr = 0; m_txdata = 0;
      idle_at = e + 1;
    end else if (job) begin
      if (waiting && e > s_at) begin
        if (tx_done) begin
          m_sent++; addr++; waiting = 0;
          if (int'(m_sent) == len) begin
            m_done = 1; m_busy = 0; job = 0; idle_at = e + 2;
          end else begin
            rd_at = e + GAP;
          end
        end else if (e - s_at == TMO) begin
          m_abort = 1; m_busy = 0; job = 0; idle_at = e + 1;
        end
      end else if (!waiting && e >= rd_at + 3 && !tx_busy) begin
        m_txs = 1; waiting = 1; s_at = e;
      end
    end else if (start && e >= idle_at) begin
      if (length == 16'd0) begin
        m_done = 1; idle_at = e + 2;
      end else begin
        job = 1; len = int'(length); m_sent = 0; addr = 0; m_busy = 1; rd_at = e; waiting = 0;
      end
    end
    if (job && e == rd_at) begin m_rd = 1; m_rdaddr = addr; end
    if (job && e == rd_at + 2) m_txdata = mem[addr[3:0]];
  end

  int         rd_cnt = 0, txs_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int         txs_edge = 0, abort_edge = 0;
  logic [15:0] rd_log[$];
  logic [7:0]  tx_log[$];
  int          gap_log[$];

  always @(negedge clk) if (e > 0) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("abort", {31'd0, abort}, {31'd0, m_abort});
    chk("rd_en", {31'd0, rd_en}, {31'd0, m_rd});
    chk("tx_start", {31'd0, tx_start}, {31'd0, m_txs});
    chk("sent_count", {16'd0, sent_count}, {16'd0, m_sent});
    chk("tx_data", {24'd0, tx_data}, {24'd0, m_txdata});
    if (m_rd) chk("rd_addr", {16'd0, rd_addr}, {16'd0, m_rdaddr});
    if (rd_en) begin
      rd_cnt++;
      rd_log.push_back(rd_addr);
      if (txdone_edge > 0) gap_log.push_back(e - txdone_edge);
    end
    if (tx_start) begin txs_cnt++; tx_log.push_back(tx_data); txs_edge = e; end
    if (done) done_cnt++;
    if (abort) begin abort_cnt++; abort_edge = e; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [15:0] len_in);
    start = 1'b1; length = len_in;
    @(negedge clk);
    start = 1'b0; length = 16'd0;
  endtask

  task automatic wait_end(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (done || abort) ok = 1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bit ok;
    int r0, t0, d0, a0, x0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h50 + 8'(i);
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43;
    reset_p = 1'b1; start = 1'b0; length = 16'd0; busy_force = 1'b0; drop_idx = -1;
    tick(3);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sent", {16'd0, sent_count}, 32'd0);
    chk("reset_txdata", {24'd0, tx_data}, 32'd0);
    reset_p = 1'b0;
    tick(2);

    // three bytes with a 4-cycle gap
    r0 = rd_log.size(); t0 = tx_log.size(); d0 = done_cnt;
    pulse_start(16'd3);
    wait_end(400, ok);
    chk("A_end", {31'd0, ok}, 32'd1);
    chk("A_sent", {16'd0, sent_count}, 32'd3);
    tick(2);
    chk("A_done_cnt", done_cnt - d0, 32'd1);
    chk("A_tx0", {24'd0, tx_log[t0]}, 32'h41);
    chk("A_tx1", {24'd0, tx_log[t0+1]}, 32'h42);
    chk("A_tx2", {24'd0, tx_log[t0+2]}, 32'h43);
    chk("A_addr1", {16'd0, rd_log[r0+1]}, 32'd1);
    chk("A_addr2", {16'd0, rd_log[r0+2]}, 32'd2);
    chk("A_gap_cnt", gap_log.size(), 32'd2);
    chk("A_gap0", gap_log[0], 32'd4);
    chk("A_gap1", gap_log[1], 32'd4);

    // zero-length job
    r0 = rd_cnt; t0 = txs_cnt;
    pulse_start(16'd0);
    chk("B_done", {31'd0, done}, 32'd1);
    chk("B_busy", {31'd0, busy}, 32'd0);
    tick(4);
    chk("B_rd", rd_cnt - r0, 32'd0);
    chk("B_txs", txs_cnt - t0, 32'd0);

    // start while running is ignored
    t0 = txs_cnt;
    pulse_start(16'd3);
    tick(5);
    pulse_start(16'd9);
    wait_end(400, ok);
    chk("C_end", {31'd0, ok}, 32'd1);
    chk("C_sent", {16'd0, sent_count}, 32'd3);
    tick(20);
    chk("C_txs", txs_cnt - t0, 32'd3);

    // transmitter busy holds off tx_start without tripping the watchdog
    t0 = txs_cnt; a0 = abort_cnt;
    busy_force = 1'b1;
    pulse_start(16'd1);
    tick(52);
    chk("D_held", txs_cnt - t0, 32'd0);
    busy_force = 1'b0;
    wait_end(200, ok);
    chk("D_end", {31'd0, done}, 32'd1);
    tick(2);
    chk("D_txs", txs_cnt - t0, 32'd1);
    chk("D_abort", abort_cnt - a0, 32'd0);

    // watchdog expiry on the second byte
    d0 = done_cnt; a0 = abort_cnt;
    drop_idx = u_idx + 2;
    pulse_start(16'd3);
    wait_end(500, ok);
    chk("E_abort_seen", {31'd0, abort}, 32'd1);
    tick(2);
    chk("E_abort_lat", abort_edge - txs_edge, 32'd100);
    chk("E_sent", {16'd0, sent_count}, 32'd1);
    chk("E_busy", {31'd0, busy}, 32'd0);
    chk("E_no_done", done_cnt - d0, 32'd0);
    chk("E_abort_cnt", abort_cnt - a0, 32'd1);
    drop_idx = -1;
    d0 = done_cnt;
    pulse_start(16'd2);
    wait_end(400, ok);
    chk("E_restart", {31'd0, done}, 32'd1);
    tick(2);
    chk("E_restart_cnt", done_cnt - d0, 32'd1);

    // reset mid-job, then a clean two-byte job
    t0 = txs_cnt; d0 = done_cnt; a0 = abort_cnt;
    pulse_start(16'd3);
    x0 = 0;
    while (txs_cnt < t0 + 2 && x0 < 200) begin tick(1); x0++; end
    chk("F_second_byte", txs_cnt - t0, 32'd2);
    tick(3);
    reset_p = 1'b1;
    tick(1);
    chk("F_rst_outs", {busy, done, abort, rd_en, tx_start, tx_data, sent_count, rd_addr},
        32'd0);
    tick(1);
    reset_p = 1'b0;
    tick(20);
    chk("F_no_done", done_cnt - d0, 32'd0);
    chk("F_no_abort", abort_cnt - a0, 32'd0);
    r0 = rd_log.size();
    pulse_start(16'd2);
    wait_end(400, ok);
    chk("F_end", {31'd0, done}, 32'd1);
    tick(2);
    chk("F_rd_cnt", rd_log.size() - r0, 32'd2);
    chk("F_addr0", {16'd0, rd_log[r0]}, 32'd0);
    chk("F_addr1", {16'd0, rd_log[r0+1]}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
